// File: rtl/hazard_stall_controller_if.sv
// Hazard inputs from the pipeline and per-stage write/flush controls back to it.
interface hazard_stall_controller_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] id_ex_rd;
  logic       id_ex_MemRead;
  logic       ex_branch_taken;
  logic       ex_mem_MemReq;
  logic       dmem_ready;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_write;
  logic       id_ex_flush;
  logic       ex_mem_write;
  logic       mem_wb_flush;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd, id_ex_MemRead,
           ex_branch_taken, ex_mem_MemReq, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd, id_ex_MemRead,
           ex_branch_taken, ex_mem_MemReq, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use bubbles, branch squash, MEM-wait freeze
// with timeout fault, plus saturating stall/flush performance counters.
module hazard_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  hazard_stall_controller_if.slave  hz,
  output logic                      mem_fault,
  output logic [1:0]                ctrl_state,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic [CNT_W-1:0]          flush_events
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_fault_q, mem_fault_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]    flush_events_q, flush_events_d;

  logic memwait, load_use, freeze, branch_apply;
  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_write_c, id_ex_flush_c;
  logic ex_mem_write_c, mem_wb_flush_c;

  always_comb begin
    memwait  = hz.ex_mem_MemReq & ~hz.dmem_ready;
    load_use = hz.id_ex_MemRead & (hz.id_ex_rd != 5'd0) &
               ((hz.id_uses_rs1 & (hz.id_ex_rd == hz.id_rs1)) |
                (hz.id_uses_rs2 & (hz.id_ex_rd == hz.id_rs2)));
    // FAULT freezes unconditionally; otherwise only an outstanding data access does
    freeze       = (state_q == ST_FAULT) | memwait;
    branch_apply = ~reset & ~freeze & hz.ex_branch_taken;
  end

  // Mealy stage controls, priority reset > freeze > branch > load-use
  always_comb begin
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_write_c  = 1'b1;
    id_ex_flush_c  = 1'b0;
    ex_mem_write_c = 1'b1;
    mem_wb_flush_c = 1'b0;
    if (reset) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_write_c  = 1'b0;
      ex_mem_write_c = 1'b0;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else if (freeze) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_write_c  = 1'b0;
      ex_mem_write_c = 1'b0;
      mem_wb_flush_c = 1'b1;
    end else if (hz.ex_branch_taken) begin
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
    end else if (load_use) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_flush_c  = 1'b1;
    end
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.if_id_write  = if_id_write_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ex_write  = id_ex_write_c;
  assign hz.id_ex_flush  = id_ex_flush_c;
  assign hz.ex_mem_write = ex_mem_write_c;
  assign hz.mem_wb_flush = mem_wb_flush_c;

  // Next-state, wait counter and sticky fault
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q;
    unique case (state_q)
      ST_RUN: begin
        if (memwait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = (MEM_TIMEOUT == 0) ? WAIT_W'(0) : WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = WAIT_W'(0);
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT))) begin
          state_d     = ST_FAULT;
          mem_fault_d = 1'b1;
        end else if (MEM_TIMEOUT != 0) begin
          wait_cnt_d = WAIT_W'(wait_cnt_q + WAIT_W'(1));
        end
      end
      ST_FAULT: begin
        state_d     = ST_FAULT;
        mem_fault_d = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = WAIT_W'(0);
      end
    endcase
  end

  // Saturating performance counters
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (~reset && (state_q != ST_FAULT) && ~pc_write_c && (stall_cycles_q != '1))
      stall_cycles_d = CNT_W'(stall_cycles_q + CNT_W'(1));
    if (branch_apply && (flush_events_q != '1))
      flush_events_d = CNT_W'(flush_events_q + CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      mem_fault_q    <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_fault_q    <= mem_fault_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign mem_fault    = mem_fault_q;
  assign ctrl_state   = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller (MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_stall_controller;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 4;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush}
  localparam logic [6:0] C_NORMAL = 7'b1101010;
  localparam logic [6:0] C_RESET  = 7'b0010101;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;

  logic             clk;
  logic             reset;
  logic             mem_fault;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  int n_checks;
  int n_errors;

  hazard_stall_controller_if hz_if ();

  hazard_stall_controller #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (hz_if),
    .mem_fault    (mem_fault),
    .ctrl_state   (ctrl_state),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {hz_if.pc_write, hz_if.if_id_write, hz_if.if_id_flush, hz_if.id_ex_write,
            hz_if.id_ex_flush, hz_if.ex_mem_write, hz_if.mem_wb_flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz_if.id_rs1          = 5'd0;
    hz_if.id_rs2          = 5'd0;
    hz_if.id_uses_rs1     = 1'b0;
    hz_if.id_uses_rs2     = 1'b0;
    hz_if.id_ex_rd        = 5'd0;
    hz_if.id_ex_MemRead   = 1'b0;
    hz_if.ex_branch_taken = 1'b0;
    hz_if.ex_mem_MemReq   = 1'b0;
    hz_if.dmem_ready      = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic set_load_use();
    hz_if.id_ex_MemRead = 1'b1;
    hz_if.id_ex_rd      = 5'd5;
    hz_if.id_rs2        = 5'd5;
    hz_if.id_uses_rs2   = 1'b1;
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    n_checks = 0;
    n_errors = 0;
    clear_inputs();

    // Reset behaviour
    cyc();
    check("reset_ctl", 32'(ctl()), 32'(C_RESET));
    cyc();
    check("reset_state", 32'(ctrl_state), 32'd0);
    check("reset_stall", 32'(stall_cycles), 32'd0);
    check("reset_flush", 32'(flush_events), 32'd0);
    check("reset_fault", 32'(mem_fault), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_ctl", 32'(ctl()), 32'(C_NORMAL));

    // Load-use: single bubble
    set_load_use();
    #1;
    check("lu_ctl", 32'(ctl()), 32'(C_LDUSE));
    cyc();
    clear_inputs();
    #1;
    check("lu_after_ctl", 32'(ctl()), 32'(C_NORMAL));
    check("lu_stall", 32'(stall_cycles), 32'd1);

    // Load into x0 never stalls
    hz_if.id_ex_MemRead = 1'b1;
    hz_if.id_ex_rd      = 5'd0;
    hz_if.id_rs1        = 5'd0;
    hz_if.id_uses_rs1   = 1'b1;
    #1;
    check("x0_ctl", 32'(ctl()), 32'(C_NORMAL));
    cyc();
    check("x0_stall", 32'(stall_cycles), 32'd1);
    clear_inputs();

    // rs1 match but rs1 unused: no stall
    hz_if.id_ex_MemRead = 1'b1;
    hz_if.id_ex_rd      = 5'd7;
    hz_if.id_rs1        = 5'd7;
    #1;
    check("unused_rs1_ctl", 32'(ctl()), 32'(C_NORMAL));
    clear_inputs();

    // Branch beats load-use
    apply_reset();
    set_load_use();
    hz_if.ex_branch_taken = 1'b1;
    #1;
    check("br_lu_ctl", 32'(ctl()), 32'(C_BRANCH));
    cyc();
    clear_inputs();
    check("br_flush_cnt", 32'(flush_events), 32'd1);
    check("br_stall_cnt", 32'(stall_cycles), 32'd0);

    // Mem wait for 3 cycles with a branch held in EX
    apply_reset();
    hz_if.ex_mem_MemReq   = 1'b1;
    hz_if.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_ctl", 32'(ctl()), 32'(C_FREEZE));
      check("mw_state", 32'(ctrl_state), (i == 0) ? 32'd0 : 32'd1);
      cyc();
    end
    check("mw_flush_held", 32'(flush_events), 32'd0);
    hz_if.dmem_ready = 1'b1;
    #1;
    check("mw_ready_ctl", 32'(ctl()), 32'(C_BRANCH));
    cyc();
    clear_inputs();
    check("mw_state_run", 32'(ctrl_state), 32'd0);
    check("mw_stall", 32'(stall_cycles), 32'd3);
    check("mw_flush", 32'(flush_events), 32'd1);

    // Timeout escalates to sticky fault
    apply_reset();
    hz_if.ex_mem_MemReq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("to_ctl", 32'(ctl()), 32'(C_FREEZE));
      check("to_fault_low", 32'(mem_fault), 32'd0);
      cyc();
    end
    check("to_state", 32'(ctrl_state), 32'd2);
    check("to_fault", 32'(mem_fault), 32'd1);
    check("to_stall", 32'(stall_cycles), 32'd5);
    hz_if.dmem_ready = 1'b1;
    #1;
    check("fault_ctl", 32'(ctl()), 32'(C_FREEZE));
    cyc();
    cyc();
    check("fault_state_held", 32'(ctrl_state), 32'd2);
    check("fault_stall_frozen", 32'(stall_cycles), 32'd5);
    reset = 1'b1;
    cyc();
    check("fault_rst_state", 32'(ctrl_state), 32'd0);
    check("fault_rst_fault", 32'(mem_fault), 32'd0);
    check("fault_rst_stall", 32'(stall_cycles), 32'd0);
    reset = 1'b0;
    clear_inputs();

    // Stall counter saturation
    apply_reset();
    set_load_use();
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 9) check("sat_mid", 32'(stall_cycles), 32'd10);
    end
    check("sat_stall", 32'(stall_cycles), 32'd15);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
